// File: rtl/mdu_mult.sv
`default_nettype none
// ============================================================================
// Module      : mdu_mult
// Description : Execute-stage iterative multiplier. Runs signed (MULT) and
//               unsigned (MULTU) operations as a radix-2 shift-add over WIDTH
//               cycles and commits the 2*WIDTH-bit product to HI/LO. Holds
//               the pipeline through stall_o while a product is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_mult #(
  parameter int         WIDTH         = 32,
  parameter logic [4:0] MULT_CONTROL  = 5'b11000,
  parameter logic [4:0] MULTU_CONTROL = 5'b11001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             adv_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int            C_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   p_q, p_d;          // {accumulator, multiplier}
  logic [WIDTH-1:0]     mcand_q, mcand_d;  // multiplicand magnitude
  logic                 neg_q, neg_d;      // product sign for signed ops
  logic [C_CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 is_mult;
  logic                 is_multu;
  logic                 start;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   p_next;
  logic [2*WIDTH-1:0]   prod;

  // Decode the request and form operand magnitudes plus one shift-add step.
  always_comb begin
    is_mult  = (alucontrol == MULT_CONTROL);
    is_multu = (alucontrol == MULTU_CONTROL);
    start    = valid_i & ~flush_i & (is_mult | is_multu);
    // -(most negative) wraps to itself, which is the correct unsigned magnitude.
    a_mag    = (is_mult && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag    = (is_mult && b_i[WIDTH-1]) ? -b_i : b_i;
    sum      = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    p_next   = {sum, p_q[WIDTH-1:1]};
    prod     = neg_q ? -p_next : p_next;
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stall_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          stall_o = 1'b1;
          state_d = S_CALC;
          p_d     = {{WIDTH{1'b0}}, a_mag};
          mcand_d = b_mag;
          neg_d   = is_mult & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          count_d = '0;
        end
      end
      S_CALC: begin
        // Stall stays up in the flush cycle; it drops once back in IDLE.
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          p_d = p_next;
          if (count_q == C_LAST) begin
            state_d = S_DONE;
            count_d = '0;
            hi_d    = prod[2*WIDTH-1:WIDTH];
            lo_d    = prod[WIDTH-1:0];
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        // The finished instruction may still sit on alucontrol; never restart here.
        done_o = 1'b1;
        if (flush_i || adv_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_mult
// Description : Self-checking bench for mdu_mult: vector table, random
//               operations against an arithmetic reference, and directed
//               flush / reset / DONE-hold sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_mult;

  localparam logic [4:0] OP_MULT  = 5'b11000;
  localparam logic [4:0] OP_MULTU = 5'b11001;
  localparam logic [4:0] OP_ADD   = 5'b00010;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [4:0]  alucontrol;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        adv_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_mult #(.WIDTH(32), .MULT_CONTROL(OP_MULT), .MULTU_CONTROL(OP_MULTU)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .alucontrol (alucontrol),
    .a_i        (a_i),
    .b_i        (b_i),
    .adv_i      (adv_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference product computed directly from the operand interpretation.
  function automatic logic [63:0] ref_prod(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub;
    if (op == OP_MULT) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply from a cycle start, wait for DONE, hold DONE for
  // `hold` extra cycles, then advance. Returns the product seen in DONE,
  // the number of stalled cycles and the start-to-DONE latency.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [63:0] prod, output int stalls, output int lat);
    logic [63:0] held;
    valid_i    = 1'b1;
    alucontrol = op;
    a_i        = a;
    b_i        = b;
    adv_i      = 1'b0;
    flush_i    = 1'b0;
    stalls     = 0;
    lat        = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done_o) break;
      stalls += int'(stall_o);
      lat++;
      tick();
    end
    prod = {hi_o, lo_o};
    chk("stall_in_done", {63'b0, stall_o}, 64'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      @(negedge clk);
      chk("done_held", {63'b0, done_o}, 64'd1);
      chk("no_restart_stall", {63'b0, stall_o}, 64'd0);
      held = {hi_o, lo_o};
      chk("hilo_held", held, prod);
    end
    adv_i = 1'b1;
    tick();
    valid_i = 1'b0;
    adv_i   = 1'b0;
    chk("done_clears_on_adv", {63'b0, done_o}, 64'd0);
  endtask

  initial begin
    logic [63:0] prod, exp, prior;
    logic [4:0]  op;
    logic [31:0] a, b;
    int          stalls, lat;

    vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[1] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA};
    vecs[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[3] = '{OP_MULTU, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[4] = '{OP_MULTU, 32'h00000003, 32'h00000005, 64'h00000000_0000000F};
    vecs[5] = '{OP_MULT,  32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};
    vecs[6] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
    vecs[7] = '{OP_MULT,  32'h00000000, 32'h80000000, 64'h00000000_00000000};

    rst = 1'b1; valid_i = 1'b0; alucontrol = 5'd0; a_i = '0; b_i = '0;
    adv_i = 1'b0; flush_i = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_hilo", {hi_o, lo_o}, 64'd0);
    chk("reset_stall", {63'b0, stall_o}, 64'd0);
    chk("reset_done", {63'b0, done_o}, 64'd0);
    tick();
    rst = 1'b0;

    // Vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, prod, stalls, lat);
      chk($sformatf("vec%0d_prod", i), prod, vecs[i].exp);
      chk($sformatf("vec%0d_stalls", i), 64'(stalls), 64'd33);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
    end

    // Random operations against the arithmetic reference
    for (int i = 0; i < 20; i++) begin
      op = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU;
      a  = $urandom();
      b  = $urandom();
      if (i % 5 == 0) a = {$urandom_range(0, 1) == 1, 31'd0};
      run_op(op, a, b, 0, prod, stalls, lat);
      exp = ref_prod(op, a, b);
      chk($sformatf("rand%0d_prod", i), prod, exp);
      chk($sformatf("rand%0d_stalls", i), 64'(stalls), 64'd33);
    end

    // Non-multiply operation: no stall, HI/LO untouched
    prior = {hi_o, lo_o};
    valid_i = 1'b1; alucontrol = OP_ADD; a_i = 32'd7; b_i = 32'd9;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("other_op_stall", {63'b0, stall_o}, 64'd0);
      tick();
    end
    chk("other_op_hilo", {hi_o, lo_o}, prior);

    // Flush in the start cycle suppresses the start
    alucontrol = OP_MULT; flush_i = 1'b1;
    @(negedge clk);
    chk("flush_start_stall", {63'b0, stall_o}, 64'd0);
    tick();
    valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("flush_start_idle", {62'b0, done_o, stall_o}, 64'd0);
    tick();

    // Flush at CALC cycle 10
    prior = {hi_o, lo_o};
    valid_i = 1'b1; alucontrol = OP_MULT; a_i = 32'd7; b_i = 32'd9;
    tick();                       // now CALC cycle 1
    repeat (9) tick();            // now CALC cycle 10
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_calc_stall_hold", {63'b0, stall_o}, 64'd1);
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("flush_calc_stall", {63'b0, stall_o}, 64'd0);
    chk("flush_calc_done", {63'b0, done_o}, 64'd0);
    repeat (40) tick();
    @(negedge clk);
    chk("flush_calc_hilo", {hi_o, lo_o}, prior);
    chk("flush_calc_no_done", {63'b0, done_o}, 64'd0);
    tick();

    // Reset in the middle of CALC
    valid_i = 1'b1; alucontrol = OP_MULTU; a_i = 32'h12345678; b_i = 32'h9ABCDEF0;
    repeat (6) tick();
    rst = 1'b1; valid_i = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
    chk("midrst_stall", {63'b0, stall_o}, 64'd0);
    chk("midrst_done", {63'b0, done_o}, 64'd0);
    tick();
    run_op(OP_MULTU, 32'd3, 32'd5, 0, prod, stalls, lat);
    chk("after_rst_prod", prod, 64'h0000000F);

    // DONE held for 4 cycles with MULT still presented, then back-to-back MULT
    run_op(OP_MULT, 32'hFFFFFFF9, 32'd6, 4, prod, stalls, lat);
    chk("hold_prod", prod, 64'hFFFFFFFF_FFFFFFD6);
    run_op(OP_MULT, 32'd1000, 32'hFFFFFC18, 0, prod, stalls, lat);
    chk("b2b_prod", prod, ref_prod(OP_MULT, 32'd1000, 32'hFFFFFC18));
    chk("b2b_latency", 64'(lat), 64'd33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
